uart_byte_tx: RTL and testbench

Byte-level UART transmitter (8N1) driven by `uart_ctrl`, which splits a 40-bit record into five bytes. Accepts one byte per level handshake on `uart_send`/`send_data` and serialises it LSB-first on `txd` at a fixed baud set by a clock-divider parameter. Reports completion on `uart_send_done` and exposes its state code on `uart_send_sta`. `uart_ctrl` holds off re-arming while that code equals 9.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_byte_tx_if.sv | 36 +++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_byte_tx.sv | 124 ++++++++++++
 tb/tb_uart_byte_tx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : State codes, frame length and default divider shared by
//                uart_byte_tx and uart_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // 12 MHz / 9600 baud
    localparam int c_CLKS_PER_BIT_DEF = 1250;

    // start + 8 data + stop
    localparam int c_FRAME_BITS = 10;
    localparam int c_DATA_BITS  = 8;

    // These codes are published on uart_send_sta and decoded by uart_ctrl.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_DATA  = 4'd2,
        ST_STOP  = 4'd3,
        ST_DONE  = 4'd9
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_byte_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx_if
//  Description : Byte handshake and serial line between a producer and the
//                UART byte transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_byte_tx_if;

    logic       uart_send;
    logic [7:0] send_data;
    logic       uart_send_done;
    logic [3:0] uart_send_sta;
    logic       txd;

    // Producer side (uart_ctrl or a testbench)
    modport master (
        output uart_send,
        output send_data,
        input  uart_send_done,
        input  uart_send_sta,
        input  txd
    );

    // Transmitter side
    modport slave (
        input  uart_send,
        input  send_data,
        output uart_send_done,
        output uart_send_sta,
        output txd
    );

endinterface : uart_byte_tx_if
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter; tick is high while the count sits at
//                CLKS_PER_BIT-1, i.e. on the last cycle of each bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      tick
);

    localparam int               c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [c_CW-1:0] r_cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clr holds the count at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 byte transmitter with level handshake. Accepts a byte
//                in IDLE, shifts it out LSB-first, then parks in DONE until
//                the requester drops uart_send. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_byte_tx_if.slave   bus
);

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [7:0]  r_shreg;
    logic [7:0]  w_shreg_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_tick;
    logic        w_cnt_clr;

    // The bit timer only runs while a frame is on the line.
    assign w_cnt_clr = !((r_state == ST_START) ||
                         (r_state == ST_DATA)  ||
                         (r_state == ST_STOP));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .tick (w_tick)
    );

    // Next state, datapath and output decode; outputs are derived from the
    // next state so they take effect on the same edge as the transition.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_idx_nxt = r_bit_idx;

        case (r_state)
            ST_IDLE: begin
                if (bus.uart_send) begin
                    w_state_nxt   = ST_START;
                    w_shreg_nxt   = bus.send_data;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_nxt   = r_shreg >> 1;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Never re-accept from here: sta=9 must outlive uart_send.
                if (!bus.uart_send) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_txd_nxt  = 1'b1;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: w_txd_nxt  = 1'b0;
            ST_DATA:  w_txd_nxt  = w_shreg_nxt[0];
            ST_DONE:  w_done_nxt = 1'b1;
            default:  w_txd_nxt  = 1'b1;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.txd            = r_txd;
    assign bus.uart_send_done = r_done;
    assign bus.uart_send_sta  = r_state;

endmodule : uart_byte_tx
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_tx
//  Description : Self-checking bench for uart_byte_tx. Expected line levels
//                come from the frame layout (start, 8 data LSB-first, stop)
//                indexed by cycles since accept.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_byte_tx;
    import uart_pkg::*;

    localparam int c_CPB   = 4;
    localparam int c_FRAME = c_FRAME_BITS * c_CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [7:0] r_b2b_q [2];
    int         b2b_acc [2];

    uart_byte_tx_if bus ();

    uart_byte_tx #(
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Line level t cycles after the accept edge, from the 8N1 frame layout.
    function automatic logic exp_txd(input logic [7:0] d, input int t);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        return f[t / c_CPB];
    endfunction

    function automatic int exp_sta(input int t);
        int b;
        b = t / c_CPB;
        if (b == 0)      return 1;
        else if (b <= 8) return 2;
        else             return 3;
    endfunction

    // One full transaction from IDLE back to IDLE.
    task automatic send_frame(input logic [7:0] d, input int hold, input logic chg,
                              input logic [7:0] d_after, input int drop_at);
        bus.uart_send = 1'b1;
        bus.send_data = d;
        for (int t = 0; t < c_FRAME; t++) begin
            tick();
            if (t == 0 && chg)  bus.send_data = d_after;
            if (t == drop_at)   bus.uart_send = 1'b0;
            check_eq($sformatf("txd %02h t%0d", d, t), bus.txd, exp_txd(d, t));
            check_eq($sformatf("sta %02h t%0d", d, t), bus.uart_send_sta, exp_sta(t));
            if (t == 0)
                check_eq("done low in frame", bus.uart_send_done, 0);
        end
        tick();
        check_eq("done at 10*CPB", bus.uart_send_done, 1);
        check_eq("sta 9 at 10*CPB", bus.uart_send_sta, 9);
        check_eq("txd high in done", bus.txd, 1);
        if (drop_at < 0) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check_eq("sta 9 while held", bus.uart_send_sta, 9);
                check_eq("done while held", bus.uart_send_done, 1);
                check_eq("txd while held", bus.txd, 1);
            end
            bus.uart_send = 1'b0;
        end
        tick();
        check_eq("sta idle after done", bus.uart_send_sta, 0);
        check_eq("done cleared", bus.uart_send_done, 0);
        check_eq("txd idle", bus.txd, 1);
    endtask

    // Registered uart_ctrl-style requester sending two bytes back to back.
    task automatic back_to_back();
        int   idx;
        int   nacc;
        int   t;
        logic dropped;
        logic pd_done;
        logic [3:0] prev_sta;
        logic e;
        r_b2b_q[0]    = 8'h01;
        r_b2b_q[1]    = 8'h80;
        nacc          = 0;
        idx           = 1;
        dropped       = 1'b0;
        pd_done       = 1'b0;
        prev_sta      = bus.uart_send_sta;
        bus.uart_send = 1'b1;
        bus.send_data = r_b2b_q[0];
        for (int k = 0; k < 3 * c_FRAME + 20; k++) begin
            tick();
            if (prev_sta == 4'd0 && bus.uart_send_sta == 4'd1 && nacc < 2) begin
                b2b_acc[nacc] = cyc;
                nacc++;
            end
            e = 1'b1;
            for (int j = 0; j < nacc; j++) begin
                t = cyc - b2b_acc[j];
                if (t >= 0 && t < c_FRAME) e = exp_txd(r_b2b_q[j], t);
            end
            check_eq($sformatf("b2b txd k%0d", k), bus.txd, e);
            // Decisions use last cycle's observation, as a registered requester would.
            if (bus.uart_send && pd_done) begin
                bus.uart_send = 1'b0;
                dropped       = 1'b1;
            end else if (!bus.uart_send && dropped && idx < 2) begin
                bus.uart_send = 1'b1;
                bus.send_data = r_b2b_q[idx];
                idx++;
                dropped = 1'b0;
            end
            pd_done  = bus.uart_send_done;
            prev_sta = bus.uart_send_sta;
        end
        check_eq("b2b accepts", nacc, 2);
        if (nacc == 2)
            check_eq("b2b spacing", b2b_acc[1] - b2b_acc[0], 10 * c_CPB + 3);
        check_eq("b2b end idle", bus.uart_send_sta, 0);
    endtask

    initial begin
        logic [7:0] d;
        int         drop;

        // Power-up: reset held three cycles with a request already pending.
        bus.uart_send = 1'b1;
        bus.send_data = 8'h55;
        rst           = 1'b1;
        repeat (3) begin
            tick();
            check_eq("rst txd", bus.txd, 1);
            check_eq("rst sta", bus.uart_send_sta, 0);
            check_eq("rst done", bus.uart_send_done, 0);
        end
        rst = 1'b0;
        send_frame(8'h55, 0, 1'b0, 8'h00, -1);

        send_frame(8'hA5, 5, 1'b0, 8'h00, -1);
        send_frame(8'h0F, 0, 1'b1, 8'hF0, -1);

        // Reset during data bit 3 of 0xFF, then a clean frame.
        bus.uart_send = 1'b1;
        bus.send_data = 8'hFF;
        tick();
        check_eq("ff accept sta", bus.uart_send_sta, 1);
        repeat (4 * c_CPB + 1) tick();
        check_eq("ff bit3 sta", bus.uart_send_sta, 2);
        check_eq("ff bit3 txd", bus.txd, 1);
        rst           = 1'b1;
        bus.send_data = 8'h3C;
        tick();
        check_eq("midrst txd", bus.txd, 1);
        check_eq("midrst sta", bus.uart_send_sta, 0);
        check_eq("midrst done", bus.uart_send_done, 0);
        rst = 1'b0;
        send_frame(8'h3C, 1, 1'b0, 8'h00, -1);

        back_to_back();

        // Random bytes, hold times, late data changes and mid-frame drops.
        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, c_FRAME - 1)) : -1;
            send_frame(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       8'($urandom), drop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_byte_tx
`default_nettype wire
